// File: rtl/note_roll_renderer.sv
`default_nettype none
// ============================================================================
// Module   : note_roll_renderer
// Purpose  : Scrolling key-press history (circular row buffer) and registered
//            colour source for the note-roll region of the frame.
//            Optional older-half fade: define NOTE_ROLL_FADE_EN.
// Revision : 1.0  initial release
// ============================================================================
module note_roll_renderer #(
    parameter int          NUM_KEYS    = 24,
    parameter int          LANE_W      = 6,
    parameter int          ROWS        = 92,
    parameter int          SCROLL_DIV  = 2,
    parameter logic [23:0] NOTE_COLOUR = 24'h3366FF,
    parameter logic [23:0] BG_COLOUR   = 24'hFFFFFF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                frameTick,
    input  logic                scrollEn,
    input  logic                clearRoll,
    input  logic [NUM_KEYS-1:0] keyState,
    input  logic [7:0]          pixX,
    input  logic [7:0]          pixY,
    output logic [23:0]         pixColour,
    output logic                pixValid,
    output logic                rollReady
);

    localparam int c_PTR_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_LANE_IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int c_TICK_W     = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [c_PTR_W-1:0]  c_LAST_ROW   = c_PTR_W'(ROWS - 1);
    localparam logic [c_TICK_W-1:0] c_LAST_TICK  = c_TICK_W'(SCROLL_DIV - 1);
    localparam logic [8:0]          c_ROWS_9     = 9'(ROWS);
    localparam logic [8:0]          c_LANE_END_9 = 9'(NUM_KEYS * LANE_W);
    localparam logic [7:0]          c_LANE_W_8   = 8'(LANE_W);

`ifdef NOTE_ROLL_FADE_EN
    localparam logic [7:0] c_HALF_ROWS_8 = 8'(ROWS / 2);
    localparam logic [8:0] c_FADE_R = ({1'b0, NOTE_COLOUR[23:16]} + {1'b0, BG_COLOUR[23:16]}) >> 1;
    localparam logic [8:0] c_FADE_G = ({1'b0, NOTE_COLOUR[15:8]}  + {1'b0, BG_COLOUR[15:8]})  >> 1;
    localparam logic [8:0] c_FADE_B = ({1'b0, NOTE_COLOUR[7:0]}   + {1'b0, BG_COLOUR[7:0]})   >> 1;
    localparam logic [23:0] c_FADE_COLOUR = {c_FADE_R[7:0], c_FADE_G[7:0], c_FADE_B[7:0]};
`endif

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_q,      state_d;
    logic [c_PTR_W-1:0]    clr_idx_q,    clr_idx_d;
    logic [c_PTR_W-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [c_TICK_W-1:0]   tick_cnt_q,   tick_cnt_d;
    logic [NUM_KEYS-1:0]   accum_q,      accum_d;
    logic                  roll_ready_q, roll_ready_d;
    logic [23:0]           pix_colour_q, pix_colour_d;
    logic                  pix_valid_q,  pix_valid_d;

    logic [NUM_KEYS-1:0]   roll_mem_q [ROWS];

    logic                  w_mem_we;
    logic [c_PTR_W-1:0]    w_mem_waddr;
    logic [NUM_KEYS-1:0]   w_mem_wdata;

    logic                  w_in_rows;
    logic                  w_in_lanes;
    logic [8:0]            w_row_sum;
    logic [8:0]            w_row_wrap;
    logic [c_PTR_W-1:0]    w_row_idx;
    logic [7:0]            w_lane_full;
    logic [c_LANE_IDX_W-1:0] w_lane;
    logic [NUM_KEYS-1:0]   w_row_bits;
    logic                  w_cell;

    // ------------------------------------------------------------------
    // Control: clear sweep, accumulation, tick division and scrolling
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        wr_ptr_d     = wr_ptr_q;
        tick_cnt_d   = tick_cnt_q;
        accum_d      = accum_q;
        roll_ready_d = roll_ready_q;
        w_mem_we     = 1'b0;
        w_mem_waddr  = wr_ptr_q;
        w_mem_wdata  = '0;

        if (clearRoll) begin
            // A clear request overrides everything, including a coincident scroll.
            state_d      = ST_CLEAR;
            clr_idx_d    = '0;
            roll_ready_d = 1'b0;
            tick_cnt_d   = '0;
            accum_d      = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    accum_d     = '0;
                    w_mem_we    = 1'b1;
                    w_mem_waddr = clr_idx_q;
                    if (clr_idx_q == c_LAST_ROW) begin
                        state_d      = ST_RUN;
                        clr_idx_d    = '0;
                        wr_ptr_d     = '0;
                        roll_ready_d = 1'b1;
                    end else begin
                        clr_idx_d = clr_idx_q + c_PTR_W'(1);
                    end
                end
                ST_RUN: begin
                    accum_d = accum_q | keyState;
                    if (frameTick && scrollEn) begin
                        if (tick_cnt_q < c_LAST_TICK) begin
                            tick_cnt_d = tick_cnt_q + c_TICK_W'(1);
                        end else begin
                            w_mem_we    = 1'b1;
                            w_mem_waddr = wr_ptr_q;
                            w_mem_wdata = accum_q | keyState;
                            wr_ptr_d    = (wr_ptr_q == c_LAST_ROW) ? '0 : wr_ptr_q + c_PTR_W'(1);
                            tick_cnt_d  = '0;
                            accum_d     = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel lookup: oldest row at pixY=0, newest at pixY=ROWS-1
    // ------------------------------------------------------------------
    always_comb begin
        w_in_rows   = ({1'b0, pixY} < c_ROWS_9);
        w_in_lanes  = ({1'b0, pixX} < c_LANE_END_9);
        w_row_sum   = {{(9 - c_PTR_W){1'b0}}, wr_ptr_q} + {1'b0, pixY};
        w_row_wrap  = (w_row_sum >= c_ROWS_9) ? (w_row_sum - c_ROWS_9) : w_row_sum;
        w_row_idx   = w_in_rows ? c_PTR_W'(w_row_wrap) : '0;
        w_lane_full = pixX / c_LANE_W_8;
        w_lane      = w_in_lanes ? c_LANE_IDX_W'(w_lane_full) : '0;
        w_row_bits  = roll_mem_q[w_row_idx];
        w_cell      = w_row_bits[w_lane];

        pix_colour_d = BG_COLOUR;
        pix_valid_d  = w_in_rows & roll_ready_q;
        if ((state_q == ST_RUN) && w_in_rows && w_in_lanes && w_cell) begin
`ifdef NOTE_ROLL_FADE_EN
            pix_colour_d = (pixY < c_HALF_ROWS_8) ? c_FADE_COLOUR : NOTE_COLOUR;
`else
            pix_colour_d = NOTE_COLOUR;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_CLEAR;
            clr_idx_q    <= '0;
            wr_ptr_q     <= '0;
            tick_cnt_q   <= '0;
            accum_q      <= '0;
            roll_ready_q <= 1'b0;
            pix_colour_q <= BG_COLOUR;
            pix_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            tick_cnt_q   <= tick_cnt_d;
            accum_q      <= accum_d;
            roll_ready_q <= roll_ready_d;
            pix_colour_q <= pix_colour_d;
            pix_valid_q  <= pix_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && w_mem_we) begin
            roll_mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign pixColour = pix_colour_q;
    assign pixValid  = pix_valid_q;
    assign rollReady = roll_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_note_roll_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_roll_renderer
// Purpose  : Directed scoreboard bench for note_roll_renderer.
// Revision : 1.0  initial release
// ============================================================================
module tb_note_roll_renderer;

    localparam int          NUM_KEYS = 24;
    localparam int          ROWS     = 92;
    localparam logic [23:0] NOTE     = 24'h3366FF;
    localparam logic [23:0] BG       = 24'hFFFFFF;
    localparam logic [23:0] FADE     = 24'h99B2FF;

    logic                clk       = 1'b0;
    logic                resetn    = 1'b0;
    logic                frameTick = 1'b0;
    logic                scrollEn  = 1'b1;
    logic                clearRoll = 1'b0;
    logic [NUM_KEYS-1:0] keyState  = '0;
    logic [7:0]          pixX      = 8'd0;
    logic [7:0]          pixY      = 8'd0;
    logic [23:0]         pixColour;
    logic                pixValid;
    logic                rollReady;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [23:0] colour;
        logic        valid;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    note_roll_renderer dut (
        .clk       (clk),
        .resetn    (resetn),
        .frameTick (frameTick),
        .scrollEn  (scrollEn),
        .clearRoll (clearRoll),
        .keyState  (keyState),
        .pixX      (pixX),
        .pixY      (pixY),
        .pixColour (pixColour),
        .pixValid  (pixValid),
        .rollReady (rollReady)
    );

    function automatic logic [23:0] note_colour(input int y);
`ifdef NOTE_ROLL_FADE_EN
        if (y < ROWS / 2) return FADE;
`endif
        return NOTE;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a coordinate, queue its expected colour, compare one cycle later.
    task automatic probe(input int x, input int y, input logic [23:0] ec,
                         input logic ev, input string tag);
        exp_t e;
        pixX     = 8'(x);
        pixY     = 8'(y);
        e.colour = ec;
        e.valid  = ev;
        e.tag    = tag;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, " colour"}, {8'h00, pixColour}, {8'h00, e.colour});
        check({e.tag, " valid"},  {31'h0, pixValid},  {31'h0, e.valid});
    endtask

    task automatic tick();
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
    endtask

    task automatic scroll();
        tick();
        tick();
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        pixX = 8'd18;
        pixY = 8'd91;
        while (rollReady !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            check({tag, " clr colour"}, {8'h00, pixColour}, {8'h00, BG});
            check({tag, " clr valid"},  {31'h0, pixValid},  32'h0);
        end
        check({tag, " clr cycles"}, n, 32'd92);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        pixX = 8'd18;
        pixY = 8'd91;
        repeat (3) @(negedge clk);
        check("rst rollReady", {31'h0, rollReady}, 32'h0);
        check("rst pixValid",  {31'h0, pixValid},  32'h0);
        check("rst pixColour", {8'h00, pixColour}, {8'h00, BG});
        resetn = 1'b1;
        wait_ready("reset");
        probe(150, 50, BG, 1'b1, "oob lane empty");

        // Key 3 held across one scroll period
        keyState = 24'h000008;
        scroll();
        keyState = '0;
        probe(18, 91, note_colour(91), 1'b1, "lane3 newest");
        probe(23, 91, note_colour(91), 1'b1, "lane3 right edge");
        probe(17, 91, BG, 1'b1, "lane2 left nbr");
        probe(24, 91, BG, 1'b1, "lane4 right nbr");
        probe(18, 90, BG, 1'b1, "older row empty");
        probe(18, 92, BG, 1'b0, "below roll");
        probe(18, 200, BG, 1'b0, "far below roll");
        scroll();
        probe(18, 90, note_colour(90), 1'b1, "lane3 moved up");
        probe(18, 91, BG, 1'b1, "newest now empty");

        // One-cycle pulse on key 0 between ticks is accumulated
        tick();
        keyState = 24'h000001;
        @(negedge clk);
        keyState = '0;
        @(negedge clk);
        tick();
        probe(0, 91, note_colour(91), 1'b1, "pulse lane0");
        probe(5, 91, note_colour(91), 1'b1, "pulse lane0 edge");
        probe(6, 91, BG, 1'b1, "pulse lane1");
        probe(18, 89, note_colour(89), 1'b1, "lane3 two up");
        probe(18, 90, BG, 1'b1, "middle row empty");

        // Frozen roll: ticks ignored, accumulation continues
        scrollEn = 1'b0;
        keyState = 24'h000020;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
        end
        keyState = '0;
        scrollEn = 1'b1;
        probe(0, 91, note_colour(91), 1'b1, "frozen lane0");
        probe(18, 89, note_colour(89), 1'b1, "frozen lane3");
        probe(30, 91, BG, 1'b1, "frozen lane5");
        tick();
        probe(0, 91, note_colour(91), 1'b1, "tickcnt held");
        tick();
        probe(30, 91, note_colour(91), 1'b1, "accum over freeze");
        probe(0, 90, note_colour(90), 1'b1, "lane0 moved up");
        probe(18, 88, note_colour(88), 1'b1, "lane3 three up");

        // Clear coincident with a scroll-qualifying tick
        tick();
        keyState  = 24'h000080;
        frameTick = 1'b1;
        clearRoll = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        clearRoll = 1'b0;
        keyState  = '0;
        check("clear rollReady", {31'h0, rollReady}, 32'h0);
        wait_ready("clearRoll");
        probe(18, 88, BG, 1'b1, "cleared lane3");
        probe(0, 91, BG, 1'b1, "cleared lane0");
        probe(30, 91, BG, 1'b1, "cleared lane5");
        probe(42, 91, BG, 1'b1, "cleared lane7");
        probe(0, 0, BG, 1'b1, "cleared oldest");
        scroll();
        probe(42, 91, BG, 1'b1, "discarded scroll");

        // One note followed by enough scrolls to push it out of the roll
        keyState = 24'h000008;
        scroll();
        keyState = '0;
        probe(18, 91, note_colour(91), 1'b1, "wrap first");
        for (int n = 2; n <= 93; n++) begin
            scroll();
            if (n == 32) probe(18, 60, note_colour(60), 1'b1, "age y60");
            if (n == 62) probe(18, 30, note_colour(30), 1'b1, "age y30");
            if (n == 92) probe(18, 0, note_colour(0), 1'b1, "oldest row");
        end
        for (int y = 0; y < ROWS; y++) probe(18, y, BG, 1'b1, "note gone");
        probe(150, 50, BG, 1'b1, "oob lane final");
        probe(159, 91, BG, 1'b1, "oob right edge");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_roll_renderer.md
Name: note_roll_renderer

Overview:
- Upstream colour source for the note-roll region (rows 0..ROWS-1) of the 160x120 frame. The piano keyboard is drawn below this region.
- Keeps a scrolling history of key-press states, one row per scroll step, in a circular row buffer.
- Returns a registered 24-bit colour for each pixel coordinate the frame scanner presents.
- Asserts rollReady once its buffer is valid, which gates the keyboard-drawing stage.

Parameters:
- NUM_KEYS, 24, number of key lanes; lane k covers x = k*LANE_W .. k*LANE_W+LANE_W-1.
- LANE_W, 6, lane width in pixels; x >= NUM_KEYS*LANE_W is background.
- ROWS, 92, history depth and note-roll height in pixels.
- SCROLL_DIV, 2, number of frame ticks per one-row scroll; must be >= 1.
- NOTE_COLOUR, 24'h3366FF, colour of a pressed-key cell.
- BG_COLOUR, 24'hFFFFFF, colour of an empty cell or out-of-lane pixel.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset, sampled on posedge clk
- frameTick  in  1  one-cycle pulse from the scanner at end of frame
- scrollEn  in  1  1 = roll advances on qualifying ticks; 0 = frozen (pause/menu states)
- clearRoll  in  1  one-cycle request to wipe the history
- keyState  in  NUM_KEYS  live key-pressed vector, bit k = lane k
- pixX  in  8  scanner X coordinate
- pixY  in  8  scanner Y coordinate
- pixColour  out  24  colour for the (pixX,pixY) presented one cycle earlier
- pixValid  out  1  1 when pixColour belongs to the roll region and the buffer is ready
- rollReady  out  1  0 while clearing, 1 otherwise

Behaviour:
- Storage: ROWS x NUM_KEYS bit array; wrPtr (0..ROWS-1) points at the oldest slot, which is the next slot written.
- FSM states: CLEAR, RUN.
- Reset, and entry to CLEAR:
  - Reset values: wrPtr=0, clrIdx=0, tickCnt=0, accum=0, pixColour=BG_COLOUR, pixValid=0, rollReady=0.
  - Reset enters CLEAR.
- CLEAR:
  - Writes 0 to row clrIdx each cycle; clrIdx increments.
  - After row ROWS-1 is written, goes to RUN with wrPtr=0 and rollReady=1 on the following cycle.
  - Lasts exactly ROWS cycles.
  - frameTick and keyState are ignored.
- RUN:
  - accum <= accum | keyState every cycle, so presses shorter than a frame still register.
- Tick qualification (RUN only):
  - A tick qualifies when frameTick=1 and scrollEn=1.
  - If tickCnt < SCROLL_DIV-1: tickCnt increments.
  - Otherwise it is a scroll: write row[wrPtr] <= accum | keyState; wrPtr <= (wrPtr==ROWS-1) ? 0 : wrPtr+1; tickCnt <= 0; accum <= 0.
- scrollEn=0: tickCnt and wrPtr hold, accum keeps ORing.
- clearRoll=1 in any state (including mid-CLEAR or coincident with a scroll):
  - Clear wins; restarts CLEAR with clrIdx=0 and rollReady=0.
  - tickCnt and accum are zeroed; the pending scroll is discarded.
- Pixel path, fixed 1-cycle latency, registered:
  - Row mapping: idx = (wrPtr + pixY) mod ROWS, computed as sum minus ROWS when sum >= ROWS (9-bit sum). pixY=ROWS-1 shows the newest row; pixY=0 shows the oldest.
  - Lane: lane = pixX / LANE_W.
  - If pixY < ROWS and pixX < NUM_KEYS*LANE_W and row[idx][lane]=1: pixColour=NOTE_COLOUR. Otherwise pixColour=BG_COLOUR.
  - pixValid = (pixY < ROWS) & rollReady, registered alongside pixColour.
  - During CLEAR: pixColour=BG_COLOUR, pixValid=0.
- Read/write same cycle: the read uses the pre-write contents and pre-update wrPtr.
- Lane wrap: pixX is 8 bits; coordinates 144..159 (default parameters) are always BG_COLOUR.

Optional Feature:
- Macro: NOTE_ROLL_FADE_EN.
- Defined:
  - Pressed cells with pixY < ROWS/2 (older half) use a faded colour: each channel of NOTE_COLOUR is averaged with BG_COLOUR, i.e. (a+b)>>1 per 8-bit channel.
  - With default parameters the faded colour is 24'h99B2FF.
  - Latency is unchanged (1 cycle).
- Not defined: every pressed cell uses NOTE_COLOUR.

Test Plan:
- Reset, hold keyState=0: rollReady=0 for exactly 92 cycles after resetn rises, then 1. During clear, pixColour=FFFFFF and pixValid=0.
- SCROLL_DIV=2, keyState[3]=1 held over 2 frameTicks, then released: pixel (18,91) gives 3366FF one cycle later; (17,91) and (24,91) give FFFFFF. After 2 more ticks the note appears at (18,90).
- keyState[0] pulsed for 1 cycle between ticks: after the scroll, (0,91)=3366FF, proving accumulation.
- 93 scrolls with only the first containing a note: wrPtr wraps 91->0 and the note leaves the roll (no 3366FF anywhere in rows 0..91). Pixel (150,50) is always FFFFFF.
- scrollEn=0 over 10 ticks: no row movement. clearRoll asserted on the same cycle as a qualifying tick: the roll empties, rollReady drops for 92 cycles, and no row is written.
- With NOTE_ROLL_FADE_EN, a note scrolled to pixY=30 reads 99B2FF; at pixY=60 it reads 3366FF.
